// File: rtl/way_data_array.sv
// Multi-way, set-indexed storage with per-way/lane-masked writes, a registered
// read port with write-first bypass, and a sequenced bulk-clear engine.
module way_data_array #(
  parameter int s_index  = 3,
  parameter int width    = 32,
  parameter int num_ways = 2,
  parameter int lane_w   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        read,
  input  logic [s_index-1:0]          rindex,
  input  logic [num_ways-1:0]         load,
  input  logic [s_index-1:0]          windex,
  input  logic [width/lane_w-1:0]     wmask,
  input  logic [width-1:0]            datain,
  input  logic                        clear,
  output logic [num_ways*width-1:0]   dataout,
  output logic                        busy,
  output logic                        state_o
);

  localparam int num_sets  = 2 ** s_index;
  localparam int num_lanes = width / lane_w;

  // Handshake: clear is a single-cycle request taken only in IDLE; while busy
  // is high load is dropped, so the controller must hold writes until busy=0.
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic [s_index-1:0]         cnt_q, cnt_d;
  logic [width-1:0]           mem_q [num_ways][num_sets];
  logic [width-1:0]           mem_d [num_ways][num_sets];
  logic [num_ways*width-1:0]  dout_q, dout_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    dout_d  = dout_q;

    case (state_q)
      IDLE: begin
        for (int w = 0; w < num_ways; w++) begin
          for (int l = 0; l < num_lanes; l++) begin
            if (load[w] && wmask[l]) begin
              mem_d[w][windex][l*lane_w +: lane_w] = datain[l*lane_w +: lane_w];
            end
          end
        end
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        for (int w = 0; w < num_ways; w++) begin
          mem_d[w][cnt_q] = '0;
        end
        // The counter wraps to zero on the final set, ready for the next clear.
        cnt_d = cnt_q + s_index'(1);
        if (cnt_q == s_index'(num_sets - 1)) begin
          state_d = IDLE;
        end
      end
    endcase

    // Write-first bypass in IDLE; during a clear the read sees pre-clear data.
    if (read) begin
      for (int w = 0; w < num_ways; w++) begin
        dout_d[w*width +: width] = (state_q == IDLE) ? mem_d[w][rindex] : mem_q[w][rindex];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      for (int w = 0; w < num_ways; w++) begin
        for (int s = 0; s < num_sets; s++) begin
          mem_q[w][s] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      mem_q   <= mem_d;
    end
  end

  assign dataout = dout_q;
  assign busy    = (state_q == CLEAR);
  assign state_o = state_q;

endmodule

// File: tb/tb_way_data_array.sv
// Randomized bench for way_data_array against an array-based reference model.
module tb_way_data_array;

  localparam int SI = 3;
  localparam int W  = 32;
  localparam int NW = 2;
  localparam int LW = 8;
  localparam int NS = 8;
  localparam int NL = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              read;
  logic [SI-1:0]     rindex;
  logic [NW-1:0]     load;
  logic [SI-1:0]     windex;
  logic [NL-1:0]     wmask;
  logic [W-1:0]      datain;
  logic              clear;
  logic [NW*W-1:0]   dataout;
  logic              busy;
  logic              dbg_state;

  int total = 0;
  int bad   = 0;

  // Reference model: contents per way/set, expected read register, clear progress.
  logic [W-1:0]      m_mem [NW][NS];
  logic [NW*W-1:0]   exp_out;
  int                m_clear_left;

  way_data_array #(.s_index(SI), .width(W), .num_ways(NW), .lane_w(LW)) dut (
    .clk(clk), .rst(rst), .read(read), .rindex(rindex), .load(load),
    .windex(windex), .wmask(wmask), .datain(datain), .clear(clear),
    .dataout(dataout), .busy(busy), .state_o(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int w = 0; w < NW; w++)
      for (int s = 0; s < NS; s++) m_mem[w][s] = '0;
    exp_out      = '0;
    m_clear_left = 0;
  endtask

  // Drives one cycle on the falling edge, advances the model, returns #1 after posedge.
  task automatic drive_cycle(input logic r, input logic [SI-1:0] ri, input logic [NW-1:0] ld,
                             input logic [SI-1:0] wi, input logic [NL-1:0] wm,
                             input logic [W-1:0] di, input logic cl);
    logic [W-1:0] bm;
    @(negedge clk);
    read = r; rindex = ri; load = ld; windex = wi; wmask = wm; datain = di; clear = cl;
    if (m_clear_left == 0) begin
      bm = '0;
      for (int l = 0; l < NL; l++) if (wm[l]) bm = bm | (W'(32'hFF) << (LW * l));
      for (int w = 0; w < NW; w++)
        if (ld[w]) m_mem[w][wi] = (m_mem[w][wi] & ~bm) | (di & bm);
      if (r) for (int w = 0; w < NW; w++) exp_out[w*W +: W] = m_mem[w][ri];
      if (cl) m_clear_left = NS;
    end else begin
      if (r) for (int w = 0; w < NW; w++) exp_out[w*W +: W] = m_mem[w][ri];
      for (int w = 0; w < NW; w++) m_mem[w][NS - m_clear_left] = '0;
      m_clear_left--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++;
    if (dataout !== '0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_state: dataout=%h busy=%b required 0/0", dataout, busy);
    end
    drive_cycle(1'b1, 3'd5, '0, '0, '0, '0, 1'b0);
    total++;
    if (dataout !== exp_out || busy !== 1'b0) begin
      bad++; $display("FAIL reset_read5: dataout=%h busy=%b required %h/0", dataout, busy, exp_out);
    end
  endtask

  task automatic test_masked_write();
    drive_cycle(1'b0, '0, 2'b01, 3'd3, 4'hF, 32'h11223344, 1'b0);
    drive_cycle(1'b0, '0, 2'b01, 3'd3, 4'b0101, 32'hAABBCCDD, 1'b0);
    drive_cycle(1'b0, '0, 2'b00, 3'd3, 4'hF, 32'hDEADBEEF, 1'b0);
    drive_cycle(1'b0, '0, 2'b11, 3'd3, 4'h0, 32'hDEADBEEF, 1'b0);
    drive_cycle(1'b1, 3'd3, '0, '0, '0, '0, 1'b0);
    total++;
    if (dataout[W-1:0] !== 32'h11BB33DD) begin
      bad++; $display("FAIL mask_way0: got %h required 11bb33dd", dataout[W-1:0]);
    end
    total++;
    if (dataout[2*W-1:W] !== 32'h0) begin
      bad++; $display("FAIL mask_way1: got %h required 00000000", dataout[2*W-1:W]);
    end
    drive_cycle(1'b0, '0, 2'b11, 3'd3, 4'hF, 32'h55555555, 1'b0);
    total++;
    if (dataout !== {32'h0, 32'h11BB33DD}) begin
      bad++; $display("FAIL read_hold: got %h required 0000000011bb33dd", dataout);
    end
  endtask

  task automatic test_bypass();
    logic [W-1:0] v0;
    v0 = $urandom;
    drive_cycle(1'b0, '0, 2'b01, 3'd6, 4'hF, v0, 1'b0);
    drive_cycle(1'b1, 3'd6, 2'b10, 3'd6, 4'hF, 32'hCAFEF00D, 1'b0);
    total++;
    if (dataout[2*W-1:W] !== 32'hCAFEF00D) begin
      bad++; $display("FAIL bypass_way1: got %h required cafef00d", dataout[2*W-1:W]);
    end
    total++;
    if (dataout[W-1:0] !== v0) begin
      bad++; $display("FAIL bypass_way0: got %h required %h", dataout[W-1:0], v0);
    end
    drive_cycle(1'b1, 3'd6, 2'b11, 3'd6, 4'b1010, $urandom, 1'b0);
    total++;
    if (dataout !== exp_out) begin
      bad++; $display("FAIL bypass_partial: got %h required %h", dataout, exp_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      drive_cycle(1'($urandom), 3'($urandom), 2'($urandom), 3'($urandom), 4'($urandom), $urandom, 1'b0);
      total++;
      if (dataout !== exp_out || busy !== 1'b0) begin
        bad++; $display("FAIL random_%0d: dataout=%h busy=%b required %h/0", i, dataout, busy, exp_out);
      end
    end
  endtask

  task automatic test_clear();
    int busy_cnt;
    for (int s = 0; s < NS; s++)
      drive_cycle(1'b0, '0, 2'b11, 3'(s), 4'hF, $urandom | 32'h1, 1'b0);
    drive_cycle(1'b0, '0, '0, '0, '0, '0, 1'b1);
    busy_cnt = busy ? 1 : 0;
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'($urandom), 3'($urandom), (i < 8) ? 2'b11 : 2'b00, 3'($urandom), 4'hF,
                  $urandom | 32'h1, (i < 6) ? 1'($urandom) : 1'b0);
      if (busy) busy_cnt++;
      total++;
      if (dataout !== exp_out || busy !== (m_clear_left != 0)) begin
        bad++; $display("FAIL clear_cycle_%0d: dataout=%h busy=%b required %h/%b",
                        i, dataout, busy, exp_out, m_clear_left != 0);
      end
    end
    total++;
    if (busy_cnt != NS) begin
      bad++; $display("FAIL clear_busy_len: got %0d cycles required %0d", busy_cnt, NS);
    end
    for (int s = 0; s < NS; s++) begin
      drive_cycle(1'b1, 3'(s), '0, '0, '0, '0, 1'b0);
      total++;
      if (dataout !== '0) begin
        bad++; $display("FAIL clear_zero_set%0d: got %h required 0", s, dataout);
      end
    end
  endtask

  task automatic test_clear_restart();
    int busy_cnt;
    drive_cycle(1'b0, '0, 2'b11, 3'd2, 4'hF, 32'h0BADF00D, 1'b1);
    busy_cnt = busy ? 1 : 0;
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b0, '0, '0, '0, '0, '0, i == 2);
      if (busy) busy_cnt++;
    end
    total++;
    if (busy_cnt != NS) begin
      bad++; $display("FAIL restart_busy_len: got %0d cycles required %0d", busy_cnt, NS);
    end
    drive_cycle(1'b1, 3'd2, '0, '0, '0, '0, 1'b0);
    total++;
    if (dataout !== exp_out || dataout !== '0) begin
      bad++; $display("FAIL clear_erases_same_cycle_write: got %h required 0", dataout);
    end
  endtask

  task automatic test_reset_mid_clear();
    int busy_cnt;
    drive_cycle(1'b0, '0, 2'b11, 3'd1, 4'hF, 32'h12345678, 1'b0);
    drive_cycle(1'b1, 3'd1, '0, '0, '0, '0, 1'b0);
    drive_cycle(1'b0, '0, '0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, '0, '0, '0, '0, 1'b0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    total++;
    if (busy !== 1'b0 || dataout !== '0) begin
      bad++; $display("FAIL async_reset: busy=%b dataout=%h required 0/0", busy, dataout);
    end
    @(negedge clk) rst = 1'b1;
    drive_cycle(1'b0, '0, '0, '0, '0, '0, 1'b1);
    busy_cnt = busy ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, '0, '0, '0, '0, '0, 1'b0);
      if (busy) busy_cnt++;
    end
    total++;
    if (busy_cnt != NS) begin
      bad++; $display("FAIL post_reset_clear_len: got %0d cycles required %0d", busy_cnt, NS);
    end
    drive_cycle(1'b1, 3'd1, '0, '0, '0, '0, 1'b0);
    total++;
    if (dataout !== exp_out) begin
      bad++; $display("FAIL post_reset_read: got %h required %h", dataout, exp_out);
    end
  endtask

  initial begin
    rst = 1'b0; read = 1'b0; rindex = '0; load = '0; windex = '0;
    wmask = '0; datain = '0; clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    test_reset();
    test_masked_write();
    test_bypass();
    test_random();
    test_clear();
    test_clear_restart();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
